// File: rtl/brick_mem_arbiter_pkg.sv
// Shared brick definitions: default widths, FSM state encoding and
// the request-index mapping used by the arbiter and its round-robin pick.
package brick_mem_arbiter_pkg;

    // Default brick-memory geometry.
    localparam int BRICK_ADDR_W   = 10;
    localparam int BRICK_HEALTH_W = 2;

    // Bit positions inside the one-hot pick vector.
    localparam int PICK_LD  = 0;
    localparam int PICK_HIT = 1;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LD_WRITE  = 3'd1,
        ST_HIT_READ  = 3'd2,
        ST_HIT_WAIT  = 3'd3,
        ST_HIT_WRITE = 3'd4,
        ST_DRAW      = 3'd5
    } arb_state_t;

endpackage

// File: rtl/brick_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between the loader and the collision requester.
// A lone requester always wins; on a tie the side that was not granted
// last wins. last_ld = 0 (the reset value) therefore favours the loader.
module rr_arbiter2
    import brick_mem_arbiter_pkg::*;
(
    input  logic       req_ld,
    input  logic       req_hit,
    input  logic       last_ld,
    output logic [1:0] pick
);

    // Purely combinational one-hot pick; at most one bit is ever set.
    always_comb begin
        pick = 2'b00;
        if (req_ld && (!req_hit || !last_ld)) begin
            pick[PICK_LD] = 1'b1;
        end else if (req_hit) begin
            pick[PICK_HIT] = 1'b1;
        end
    end

endmodule

// File: rtl/brick_mem_arbiter.sv
// Brick-memory arbiter: serialises loader writes and collision hits onto a
// single brick RAM port, then hands each changed brick to the drawing
// engine. Every output comes from a register or from the state register,
// so no input reaches an output combinationally.
module brick_mem_arbiter
    import brick_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = BRICK_ADDR_W,
    parameter int HEALTH_W = BRICK_HEALTH_W
) (
    input  logic                clk,
    input  logic                reset,

    // Loader write requests
    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [HEALTH_W-1:0] ld_health,
    output logic                ld_gnt,

    // Collision (health decrement) requests
    input  logic                hit_req,
    input  logic [ADDR_W-1:0]   hit_addr,
    output logic                hit_gnt,
    output logic                hit_destroyed,

    // Brick RAM port (read data valid one cycle after the address)
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [HEALTH_W-1:0] mem_wdata,
    input  logic [HEALTH_W-1:0] mem_rdata,

    // Drawing-engine handshake
    output logic                draw_req,
    output logic [ADDR_W-1:0]   draw_addr,
    output logic [HEALTH_W-1:0] draw_health,
    input  logic                draw_ack,

    output logic                busy
);

    arb_state_t          state_reg;
    logic                last_ld_reg;     // 1: loader was granted most recently
    logic [ADDR_W-1:0]   addr_reg;        // slot of the transaction in flight
    logic [HEALTH_W-1:0] health_reg;      // loader value or captured hit health

    logic                ld_gnt_reg;
    logic                hit_gnt_reg;
    logic                hit_destroyed_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic                mem_we_reg;
    logic [HEALTH_W-1:0] mem_wdata_reg;
    logic                draw_req_reg;
    logic [ADDR_W-1:0]   draw_addr_reg;
    logic [HEALTH_W-1:0] draw_health_reg;

    logic [1:0]          pick;

    rr_arbiter2 u_rr (
        .req_ld  (ld_req),
        .req_hit (hit_req),
        .last_ld (last_ld_reg),
        .pick    (pick)
    );

    // Transaction FSM with registered outputs. Pulse outputs default low each
    // cycle; the draw outputs and the RAM address hold until changed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            last_ld_reg       <= 1'b0;
            addr_reg          <= '0;
            health_reg        <= '0;
            ld_gnt_reg        <= 1'b0;
            hit_gnt_reg       <= 1'b0;
            hit_destroyed_reg <= 1'b0;
            mem_addr_reg      <= '0;
            mem_we_reg        <= 1'b0;
            mem_wdata_reg     <= '0;
            draw_req_reg      <= 1'b0;
            draw_addr_reg     <= '0;
            draw_health_reg   <= '0;
        end else begin
            ld_gnt_reg        <= 1'b0;
            hit_gnt_reg       <= 1'b0;
            hit_destroyed_reg <= 1'b0;
            mem_we_reg        <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (pick[PICK_LD]) begin
                        // Loader write is committed in the very next cycle.
                        addr_reg      <= ld_addr;
                        health_reg    <= ld_health;
                        last_ld_reg   <= 1'b1;
                        mem_addr_reg  <= ld_addr;
                        mem_wdata_reg <= ld_health;
                        mem_we_reg    <= 1'b1;
                        ld_gnt_reg    <= 1'b1;
                        state_reg     <= ST_LD_WRITE;
                    end else if (pick[PICK_HIT]) begin
                        // Present the read address; data returns a cycle later.
                        addr_reg      <= hit_addr;
                        last_ld_reg   <= 1'b0;
                        mem_addr_reg  <= hit_addr;
                        state_reg     <= ST_HIT_READ;
                    end
                end

                ST_LD_WRITE: begin
                    draw_req_reg    <= 1'b1;
                    draw_addr_reg   <= addr_reg;
                    draw_health_reg <= health_reg;
                    state_reg       <= ST_DRAW;
                end

                ST_HIT_READ: begin
                    state_reg <= ST_HIT_WAIT;
                end

                ST_HIT_WAIT: begin
                    // RAM data is valid now; set up the write-back cycle.
                    // An empty slot is left alone so health never wraps.
                    health_reg  <= mem_rdata;
                    hit_gnt_reg <= 1'b1;
                    if (mem_rdata != '0) begin
                        mem_we_reg        <= 1'b1;
                        mem_wdata_reg     <= mem_rdata - HEALTH_W'(1);
                        hit_destroyed_reg <= (mem_rdata == HEALTH_W'(1));
                    end
                    state_reg <= ST_HIT_WRITE;
                end

                ST_HIT_WRITE: begin
                    if (health_reg != '0) begin
                        draw_req_reg    <= 1'b1;
                        draw_addr_reg   <= addr_reg;
                        draw_health_reg <= health_reg - HEALTH_W'(1);
                        state_reg       <= ST_DRAW;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end

                ST_DRAW: begin
                    if (draw_ack) begin
                        draw_req_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_gnt        = ld_gnt_reg;
    assign hit_gnt       = hit_gnt_reg;
    assign hit_destroyed = hit_destroyed_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_we        = mem_we_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign draw_req      = draw_req_reg;
    assign draw_addr     = draw_addr_reg;
    assign draw_health   = draw_health_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_brick_mem_arbiter.sv
// Directed bench for brick_mem_arbiter with a behavioural brick RAM and a
// transaction scoreboard (loader writes, hit write-backs, draw requests).
module tb_brick_mem_arbiter;

    localparam int AW = 10;
    localparam int HW = 2;

    localparam logic [1:0] K_LD   = 2'd0;
    localparam logic [1:0] K_HIT  = 2'd1;
    localparam logic [1:0] K_DRAW = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic          we;
        logic [AW-1:0] addr;
        logic [HW-1:0] data;
        logic          dest;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [HW-1:0] ld_health = '0;
    logic          ld_gnt;
    logic          hit_req = 1'b0;
    logic [AW-1:0] hit_addr = '0;
    logic          hit_gnt;
    logic          hit_destroyed;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [HW-1:0] mem_wdata;
    logic [HW-1:0] mem_rdata;
    logic          draw_req;
    logic [AW-1:0] draw_addr;
    logic [HW-1:0] draw_health;
    logic          draw_ack = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    ev_t exp_q[$];
    logic draw_req_q = 1'b0;
    logic [HW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    brick_mem_arbiter #(.ADDR_W(AW), .HEALTH_W(HW)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .ld_health     (ld_health),
        .ld_gnt        (ld_gnt),
        .hit_req       (hit_req),
        .hit_addr      (hit_addr),
        .hit_gnt       (hit_gnt),
        .hit_destroyed (hit_destroyed),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .draw_req      (draw_req),
        .draw_addr     (draw_addr),
        .draw_health   (draw_health),
        .draw_ack      (draw_ack),
        .busy          (busy)
    );

    // Brick RAM: registered read of the old contents, write-through after it.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic we, input logic [AW-1:0] a,
                               input logic [HW-1:0] d, input logic dest);
        ev_t e;
        e.kind = k; e.we = we; e.addr = a; e.data = d; e.dest = dest;
        return e;
    endfunction

    task automatic sb_take(input string tag, input ev_t obs);
        ev_t e;
        $display("txn %s kind=%0d we=%0d addr=%0d data=%0d dest=%0d @cyc %0d",
                 tag, obs.kind, obs.we, obs.addr, obs.data, obs.dest, cyc);
        check({tag, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (ld_gnt)
                sb_take("sb_ld", mk(K_LD, mem_we, mem_addr, mem_wdata, hit_destroyed));
            if (hit_gnt)
                sb_take("sb_hit", mk(K_HIT, mem_we, mem_addr, mem_we ? mem_wdata : '0, hit_destroyed));
            if (draw_req && !draw_req_q)
                sb_take("sb_draw", mk(K_DRAW, 1'b0, draw_addr, draw_health, 1'b0));
        end
        draw_req_q <= draw_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30 && busy; i++) tick();
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic ack_draw();
        draw_ack = 1'b1;
        tick();
        draw_ack = 1'b0;
        check("draw_done", 32'({busy, draw_req}), 32'd0);
    endtask

    // Issues a hit and advances to the HIT_WRITE cycle (cycle 3).
    task automatic hit_to_write(input logic [AW-1:0] a);
        hit_addr = a;
        hit_req  = 1'b1;
        tick();
        check("hit_read", 32'({mem_we, hit_gnt, busy, mem_addr}), 32'({1'b0, 1'b0, 1'b1, a}));
        hit_req  = 1'b0;
        hit_addr = '1;
        tick();
        check("hit_wait", 32'({mem_we, hit_gnt, busy}), 32'b001);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq;
        int gcyc[4];
        int ng;
        int nh;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_ctrl", 32'({ld_gnt, hit_gnt, hit_destroyed, mem_we, draw_req, busy}), 32'd0);
        check("rst_data", 32'({mem_addr, mem_wdata, draw_addr, draw_health}), 32'd0);
        reset = 1'b0;
        tick();

        // Contention: both requests held, draw acked immediately
        mem[11] = 2'd3;
        ld_addr = 10; ld_health = 2; hit_addr = 11;
        ld_req = 1'b1; hit_req = 1'b1; draw_ack = 1'b1;
        exp_q.push_back(mk(K_LD,   1'b1, 10, 2'd2, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 10, 2'd2, 1'b0));
        exp_q.push_back(mk(K_HIT,  1'b1, 11, 2'd2, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 11, 2'd2, 1'b0));
        exp_q.push_back(mk(K_LD,   1'b1, 10, 2'd2, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 10, 2'd2, 1'b0));
        exp_q.push_back(mk(K_HIT,  1'b1, 11, 2'd1, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 11, 2'd1, 1'b0));
        seq = '0; ng = 0; nh = 0;
        for (int i = 0; i < 4; i++) gcyc[i] = 0;
        for (int i = 0; i < 60 && nh < 2; i++) begin
            tick();
            if (ld_gnt) begin
                seq = {seq[2:0], 1'b0};
                if (ng < 4) gcyc[ng] = cyc;
                ng++;
            end
            if (hit_gnt) begin
                seq = {seq[2:0], 1'b1};
                if (ng < 4) gcyc[ng] = cyc;
                ng++;
                nh++;
            end
        end
        ld_req = 1'b0; hit_req = 1'b0;
        check("rr_count", 32'(ng), 32'd4);
        check("rr_order", 32'(seq), 32'b0101);
        check("space_ld_hit", 32'(gcyc[1] - gcyc[0]), 32'd5);
        check("space_hit_ld", 32'(gcyc[2] - gcyc[1]), 32'd3);
        check("space_ld_hit2", 32'(gcyc[3] - gcyc[2]), 32'd5);
        wait_idle("rr_idle");
        draw_ack = 1'b0;

        // Loader write: slot 5 <- 3; inputs change after the grant
        exp_q.push_back(mk(K_LD,   1'b1, 5, 2'd3, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 5, 2'd3, 1'b0));
        ld_addr = 5; ld_health = 3; ld_req = 1'b1;
        tick();
        check("ld_c1", 32'({ld_gnt, mem_we, mem_addr, mem_wdata, busy}), 32'({1'b1, 1'b1, 10'd5, 2'd3, 1'b1}));
        ld_req = 1'b0; ld_addr = 9; ld_health = 1;
        tick();
        check("ld_c2", 32'({draw_req, draw_addr, draw_health, ld_gnt, mem_we}), 32'({1'b1, 10'd5, 2'd3, 1'b0, 1'b0}));
        ack_draw();

        // Hit on health 2 -> writes 1, draw 1
        mem[4] = 2'd2;
        exp_q.push_back(mk(K_HIT,  1'b1, 4, 2'd1, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 4, 2'd1, 1'b0));
        hit_to_write(4);
        check("hit2_c3", 32'({hit_gnt, mem_we, mem_wdata, hit_destroyed}), 32'({1'b1, 1'b1, 2'd1, 1'b0}));
        tick();
        check("hit2_c4", 32'({draw_req, draw_addr, draw_health, hit_gnt}), 32'({1'b1, 10'd4, 2'd1, 1'b0}));
        ack_draw();

        // Destroying hit on slot 33 (health 1)
        mem[33] = 2'd1;
        exp_q.push_back(mk(K_HIT,  1'b1, 33, 2'd0, 1'b1));
        exp_q.push_back(mk(K_DRAW, 1'b0, 33, 2'd0, 1'b0));
        hit_to_write(33);
        check("kill_c3", 32'({hit_gnt, mem_we, mem_wdata, hit_destroyed}), 32'({1'b1, 1'b1, 2'd0, 1'b1}));
        tick();
        check("kill_c4", 32'({draw_req, draw_addr, draw_health}), 32'({1'b1, 10'd33, 2'd0}));
        ack_draw();

        // Hit on the now-empty slot 33: no write, no draw
        exp_q.push_back(mk(K_HIT, 1'b0, 33, 2'd0, 1'b0));
        hit_to_write(33);
        check("empty_c3", 32'({hit_gnt, mem_we, hit_destroyed}), 32'b100);
        tick();
        check("empty_c4", 32'({draw_req, busy}), 32'd0);

        // Draw back-pressure with a hit request waiting
        exp_q.push_back(mk(K_LD,   1'b1, 20, 2'd1, 1'b0));
        exp_q.push_back(mk(K_DRAW, 1'b0, 20, 2'd1, 1'b0));
        exp_q.push_back(mk(K_HIT,  1'b0, 33, 2'd0, 1'b0));
        ld_addr = 20; ld_health = 1; ld_req = 1'b1;
        tick();
        check("bp_gnt", 32'(ld_gnt), 32'd1);
        ld_req = 1'b0; hit_addr = 33; hit_req = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 32'({draw_req, draw_addr, draw_health, busy, ld_gnt, hit_gnt, mem_we}),
                  32'({1'b1, 10'd20, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0}));
            tick();
        end
        ack_draw();
        nh = 0;
        for (int i = 0; i < 20 && nh == 0; i++) begin
            tick();
            if (hit_gnt) nh = 1;
        end
        hit_req = 1'b0;
        check("bp_hit_after", 32'(nh), 32'd1);
        wait_idle("bp_idle");

        // Reset while in HIT_WAIT
        mem[40] = 2'd3;
        hit_addr = 40; hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_ctrl", 32'({ld_gnt, hit_gnt, hit_destroyed, mem_we, draw_req, busy}), 32'd0);
        check("mid_rst_data", 32'({mem_addr, mem_wdata, draw_addr, draw_health}), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_quiet", 32'({mem_we, hit_gnt, busy}), 32'd0);
        end
        check("mid_mem40", 32'(mem[40]), 32'd3);

        // Final RAM contents and scoreboard drain
        check("mem5",  32'(mem[5]),  32'd3);
        check("mem4",  32'(mem[4]),  32'd1);
        check("mem10", 32'(mem[10]), 32'd2);
        check("mem11", 32'(mem[11]), 32'd1);
        check("mem20", 32'(mem[20]), 32'd1);
        check("mem33", 32'(mem[33]), 32'd0);
        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
